text_writer: RTL

TEXT_WRITER -- requirements
Module: text_writer

---
 rtl/text_writer.sv | 113 +++++++++++
 1 files changed

// File: rtl/text_writer.sv
// text_writer: turns a host byte stream into text-buffer writes, tracking a cursor
// and handling CR, BS, LF, FF, line wrap, scroll-up and full-screen clear.
module text_writer #(
   parameter int         COLS  = 80,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic        pixel_clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        buf_wr_en,
   output logic [11:0] buf_wr_addr,
   output logic [7:0]  buf_wr_data,
   output logic [11:0] buf_rd_addr,
   input  logic [7:0]  buf_rd_data,
   output logic [4:0]  cursor_row,
   output logic [6:0]  cursor_col,
   output logic        busy
);
   localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
   localparam logic [11:0] COLS12     = 12'(COLS);
   localparam logic [11:0] COPY_END   = 12'(COLS * (ROWS - 1) - 1);
   localparam logic [11:0] FILL_START = 12'(COLS * (ROWS - 1));
   localparam logic [11:0] LAST_ADDR  = 12'(COLS * ROWS - 1);

   typedef enum logic [2:0] {IDLE, WRITE, SCROLL_COPY, SCROLL_FILL, CLEAR} state_t;
   state_t      state;
   logic [7:0]  wr_data_q;
   logic [11:0] cursor_addr;

   assign in_ready    = state == IDLE;
   assign busy        = state != IDLE;
   assign cursor_addr = 12'(cursor_row) * COLS12 + 12'(cursor_col);
   // copy writes forward the read data returned for the previous cycle's read address
   assign buf_wr_data = state == SCROLL_COPY ? buf_rd_data : wr_data_q;

   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cursor_row  <= '0;
         cursor_col  <= '0;
         buf_wr_en   <= 1'b0;
         buf_wr_addr <= '0;
         wr_data_q   <= '0;
         buf_rd_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               buf_wr_en <= 1'b0;
               if (in_valid) begin
                  if (in_data >= 8'h20) begin
                     state       <= WRITE;
                     buf_wr_en   <= 1'b1;
                     buf_wr_addr <= cursor_addr;
                     wr_data_q   <= in_data;
                  end else if (in_data == 8'h0D) begin
                     cursor_col <= '0;
                  end else if (in_data == 8'h08) begin
                     if (cursor_col != '0) cursor_col <= cursor_col - 7'd1;
                  end else if (in_data == 8'h0A) begin
                     if (cursor_row != LAST_ROW) cursor_row <= cursor_row + 5'd1;
                     else begin
                        state       <= SCROLL_COPY;
                        buf_rd_addr <= COLS12;
                     end
                  end else if (in_data == 8'h0C) begin
                     state       <= CLEAR;
                     cursor_row  <= '0;
                     cursor_col  <= '0;
                     buf_wr_en   <= 1'b1;
                     buf_wr_addr <= '0;
                     wr_data_q   <= BLANK;
                  end
               end
            end
            WRITE: begin
               buf_wr_en <= 1'b0;
               state     <= IDLE;
               if (cursor_col != LAST_COL) cursor_col <= cursor_col + 7'd1;
               else begin
                  cursor_col <= '0;
                  if (cursor_row != LAST_ROW) cursor_row <= cursor_row + 5'd1;
                  else begin
                     state       <= SCROLL_COPY;
                     buf_rd_addr <= COLS12;
                  end
               end
            end
            SCROLL_COPY: begin
               if (buf_wr_en && buf_wr_addr == COPY_END) begin
                  state       <= SCROLL_FILL;
                  buf_wr_addr <= FILL_START;
                  wr_data_q   <= BLANK;
               end else begin
                  buf_wr_en   <= 1'b1;
                  buf_wr_addr <= buf_wr_en ? buf_wr_addr + 12'd1 : '0;
                  if (buf_rd_addr != LAST_ADDR) buf_rd_addr <= buf_rd_addr + 12'd1;
               end
            end
            SCROLL_FILL, CLEAR: begin
               if (buf_wr_addr == LAST_ADDR) begin
                  state     <= IDLE;
                  buf_wr_en <= 1'b0;
               end else buf_wr_addr <= buf_wr_addr + 12'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
